// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl_pkg
//  Description : Shared LEGv8 control bundle, opcode constants and the hazard
//                FSM state type used by the decode/execute pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_ctrl_pkg;

    typedef struct packed {
        logic [1:0] ALUSrc;
        logic [1:0] BrTaken;
        logic [1:0] MemToReg;
        logic       Reg2Loc;
        logic       RegWrite;
        logic       MemWrite;
        logic       UncondBr;
        logic       read_enable;
        logic       flags_we;
        logic       forwarden;
        logic       ChooseRd;
        logic [2:0] ALUOp;
    } ctrl_t;

    localparam ctrl_t       CTRL_BUBBLE = '0;
    localparam logic [4:0]  XZR         = 5'd31;
    localparam logic [7:0]  OP_CBZ      = 8'b10110100;
    localparam logic [7:0]  OP_BCOND    = 8'b01010100;
    localparam logic [10:0] OP_BR       = 11'b11010110000;
    localparam logic [4:0]  COND_LT     = 5'b01011;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL2 = 2'd1,
        STALL1 = 2'd2
    } hz_state_t;

    // The zero register is never a real producer, so it can never create a hazard.
    function automatic logic reg_hit(input logic [4:0] r,
                                     input logic [4:0] rn,
                                     input logic [4:0] rm);
        return (r != XZR) && ((r == rn) || (r == rm));
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : id_hazard_detect
//  Description : Combinational source-register extraction for the ID-stage
//                instruction and the LU1/BR1/BR2/FL1 hazard flags.
//  Revision    : 1.0  initial release
// ============================================================================
module id_hazard_detect
    import cpu_ctrl_pkg::*;
(
    input  logic [10:0] i_id_op,
    input  logic [4:0]  i_id_rm_hi,
    input  logic [4:0]  i_id_rn,
    input  logic [4:0]  i_id_rt,
    input  logic        i_reg2loc,
    input  logic [4:0]  i_ex_rd,
    input  logic        i_ex_valid,
    input  logic        i_ex_read_enable,
    input  logic        i_ex_reg_write,
    input  logic        i_ex_flags_we,
    input  logic [4:0]  i_mem_rd,
    input  logic        i_mem_load,
    output logic        o_lu1,
    output logic        o_br1,
    output logic        o_br2,
    output logic        o_fl1
);

    logic [4:0] w_rm;
    logic       w_is_cb;
    logic       w_is_blt;
    logic       w_ex_hit;
    logic       w_mem_hit;

    assign w_rm      = i_reg2loc ? i_id_rm_hi : i_id_rt;
    assign w_is_cb   = (i_id_op[10:3] == OP_CBZ) || (i_id_op == OP_BR);
    assign w_is_blt  = (i_id_op[10:3] == OP_BCOND) && (i_id_rt == COND_LT);
    assign w_ex_hit  = reg_hit(i_ex_rd, i_id_rn, w_rm);
    assign w_mem_hit = reg_hit(i_mem_rd, i_id_rn, w_rm);

    // Branches resolve in ID, so they need operands one stage earlier than ALU ops.
    assign o_lu1 = i_ex_read_enable & i_ex_valid & w_ex_hit;
    assign o_br2 = w_is_cb & i_ex_read_enable & w_ex_hit;
    assign o_br1 = w_is_cb & ((i_ex_reg_write & w_ex_hit) | (i_mem_load & w_mem_hit));
    assign o_fl1 = w_is_blt & i_ex_flags_we & i_ex_valid;

endmodule
`default_nettype wire

// File: rtl/id_ex_hazard_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_hazard_stage
//  Description : IF/ID and ID/EX pipeline registers with load-use / branch
//                hazard stalling, bubble injection and branch flush.
//                Optional HAZARD_STATS_EN adds stall/flush event counters.
//  Revision    : 1.0  initial release
// ============================================================================
module id_ex_hazard_stage
    import cpu_ctrl_pkg::*;
#(
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32
)(
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] if_instr,
    input  logic [PC_W-1:0]    if_pc,
    input  logic               if_valid,
    input  logic               flush,
    input  ctrl_t              dec_ctrl,
    input  logic [4:0]         mem_rd,
    input  logic               mem_load,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc,
    output ctrl_t              ex_ctrl,
    output logic [INSTR_W-1:0] ex_instr,
    output logic [PC_W-1:0]    ex_pc,
    output logic               ex_valid,
`ifdef HAZARD_STATS_EN
    output logic [31:0]        stall_cnt,
    output logic [31:0]        flush_cnt,
`endif
    output logic               pc_stall
);

    localparam logic [31:0] c_CNT_MAX = 32'hFFFF_FFFF;

    logic [INSTR_W-1:0] r_id_instr;
    logic [PC_W-1:0]    r_id_pc;
    logic               r_id_valid;
    ctrl_t              r_ex_ctrl;
    logic [INSTR_W-1:0] r_ex_instr;
    logic [PC_W-1:0]    r_ex_pc;
    logic               r_ex_valid;
    hz_state_t          r_state;
    hz_state_t          w_next_state;
    logic               w_stall;
    logic               w_lu1;
    logic               w_br1;
    logic               w_br2;
    logic               w_fl1;

    id_hazard_detect u_hazard (
        .i_id_op          (r_id_instr[31:21]),
        .i_id_rm_hi       (r_id_instr[20:16]),
        .i_id_rn          (r_id_instr[9:5]),
        .i_id_rt          (r_id_instr[4:0]),
        .i_reg2loc        (dec_ctrl.Reg2Loc),
        .i_ex_rd          (r_ex_instr[4:0]),
        .i_ex_valid       (r_ex_valid),
        .i_ex_read_enable (r_ex_ctrl.read_enable),
        .i_ex_reg_write   (r_ex_ctrl.RegWrite),
        .i_ex_flags_we    (r_ex_ctrl.flags_we),
        .i_mem_rd         (mem_rd),
        .i_mem_load       (mem_load),
        .o_lu1            (w_lu1),
        .o_br1            (w_br1),
        .o_br2            (w_br2),
        .o_fl1            (w_fl1)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= RUN;
        else       r_state <= w_next_state;
    end

    // STALL1 re-evaluates hazards exactly like RUN; only STALL2 stalls blindly.
    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        case (r_state)
            STALL2: begin
                w_stall      = 1'b1;
                w_next_state = STALL1;
            end
            default: begin
                if (w_br2) begin
                    w_stall      = 1'b1;
                    w_next_state = STALL2;
                end else if (w_lu1 | w_br1 | w_fl1) begin
                    w_stall      = 1'b1;
                    w_next_state = STALL1;
                end else begin
                    w_next_state = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_id_instr <= '0;
            r_id_pc    <= '0;
            r_id_valid <= 1'b0;
            r_ex_ctrl  <= CTRL_BUBBLE;
            r_ex_instr <= '0;
            r_ex_pc    <= '0;
            r_ex_valid <= 1'b0;
        end else if (w_stall) begin
            r_ex_ctrl  <= CTRL_BUBBLE;
            r_ex_instr <= '0;
            r_ex_pc    <= '0;
            r_ex_valid <= 1'b0;
        end else begin
            if (flush || !if_valid) begin
                r_id_instr <= '0;
                r_id_pc    <= '0;
                r_id_valid <= 1'b0;
            end else begin
                r_id_instr <= if_instr;
                r_id_pc    <= if_pc;
                r_id_valid <= 1'b1;
            end
            r_ex_ctrl  <= r_id_valid ? dec_ctrl : CTRL_BUBBLE;
            r_ex_instr <= r_id_instr;
            r_ex_pc    <= r_id_pc;
            r_ex_valid <= r_id_valid;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != c_CNT_MAX))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (flush && !w_stall && (r_flush_cnt != c_CNT_MAX))
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

    a_no_flush_while_stall: assert property (@(posedge clk) disable iff (reset)
        !(flush && w_stall));

    assign id_instr = r_id_instr;
    assign id_pc    = r_id_pc;
    assign ex_ctrl  = r_ex_ctrl;
    assign ex_instr = r_ex_instr;
    assign ex_pc    = r_ex_pc;
    assign ex_valid = r_ex_valid;
    assign pc_stall = w_stall;

endmodule
`default_nettype wire
